// File: rtl/input_unshuffle_if.sv
// Pixel-stream input and SRAM write-port bundle for input_unshuffle.
interface input_unshuffle_if #(
  parameter int CH_NUM       = 4,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 8
);
  localparam int NB = CH_NUM * ACT_PER_ADDR;
  localparam int DW = NB * BW_PER_ACT;

  logic                  enable;
  logic                  in_valid;
  logic [BW_PER_ACT-1:0] input_data;
  logic                  sram_wen_a0;
  logic                  sram_wen_a1;
  logic                  sram_wen_a2;
  logic                  sram_wen_a3;
  logic [NB-1:0]         sram_bytemask_a;
  logic [5:0]            sram_waddr_a;
  logic [DW-1:0]         sram_wdata_a;
  logic                  busy;
  logic                  done;

  // Pixel source / SRAM observer side
  modport master (
    output enable, in_valid, input_data,
    input  sram_wen_a0, sram_wen_a1, sram_wen_a2, sram_wen_a3,
    input  sram_bytemask_a, sram_waddr_a, sram_wdata_a, busy, done
  );

  // Unshuffle engine side
  modport slave (
    input  enable, in_valid, input_data,
    output sram_wen_a0, sram_wen_a1, sram_wen_a2, sram_wen_a3,
    output sram_bytemask_a, sram_waddr_a, sram_wdata_a, busy, done
  );
endinterface

// File: rtl/input_unshuffle.sv
// Scatters a raster-order IMG_W x IMG_W image into four SRAM banks using a
// two-level 2x2 pixel unshuffle: one byte-masked write per accepted pixel.
module input_unshuffle #(
  parameter int CH_NUM       = 4,
  parameter int ACT_PER_ADDR = 4,
  parameter int BW_PER_ACT   = 8,
  parameter int IMG_W        = 28
) (
  input  logic            clk,
  input  logic            rst_n,
  input_unshuffle_if.slave bus
);
  localparam int NB = CH_NUM * ACT_PER_ADDR;
  localparam int DW = NB * BW_PER_ACT;
  localparam int CW = $clog2(IMG_W);
  localparam int KW = $clog2(NB);

  typedef enum logic {IDLE, LOAD} state_t;

  state_t          state;
  logic [CW-1:0]   x, y;
  logic [3:0]      wen_q;
  logic [NB-1:0]   mask_q;
  logic [5:0]      waddr_q;
  logic [DW-1:0]   wdata_q;
  logic            busy_q, done_q;

  int unsigned     c, p, uy, ux, br, bc;
  logic [1:0]      bank;
  logic [5:0]      addr;
  logic [KW-1:0]   k;
  logic            last_pix;
  logic            x_wrap;

  // Destination (bank, address, byte lane) of the pixel at the current (y,x)
  always_comb begin
    c    = (32'(y) % 2) * 2 + (32'(x) % 2);
    uy   = 32'(y) / 2;
    ux   = 32'(x) / 2;
    p    = (uy % 2) * 2 + (ux % 2);
    br   = uy / 2;
    bc   = ux / 2;
    k    = KW'(c * ACT_PER_ADDR + p);
    bank = 2'((br % 2) * 2 + (bc % 2));
    addr = 6'((br / 2) * 4 + (bc / 2));
    x_wrap   = (x == CW'(IMG_W - 1));
    last_pix = x_wrap && (y == CW'(IMG_W - 1));
  end

  // Load FSM, raster counters and registered write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= '0;
      y       <= '0;
      wen_q   <= '1;
      mask_q  <= '1;
      waddr_q <= '0;
      wdata_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      wen_q  <= '1;
      mask_q <= '1;
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          // busy drops here after the done cycle unless a new load starts at once
          busy_q <= bus.enable;
          if (bus.enable) begin
            state <= LOAD;
            x     <= '0;
            y     <= '0;
          end
        end
        LOAD: begin
          if (bus.in_valid) begin
            wen_q   <= ~(4'b0001 << bank);
            mask_q  <= ~(NB'(1) << k);
            waddr_q <= addr;
            wdata_q <= {NB{bus.input_data}};
            if (last_pix) begin
              state  <= IDLE;
              done_q <= 1'b1;
              x      <= '0;
              y      <= '0;
            end else if (x_wrap) begin
              x <= '0;
              y <= y + 1'b1;
            end else begin
              x <= x + 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.sram_wen_a0     = wen_q[0];
  assign bus.sram_wen_a1     = wen_q[1];
  assign bus.sram_wen_a2     = wen_q[2];
  assign bus.sram_wen_a3     = wen_q[3];
  assign bus.sram_bytemask_a = mask_q;
  assign bus.sram_waddr_a    = waddr_q;
  assign bus.sram_wdata_a    = wdata_q;
  assign bus.busy            = busy_q;
  assign bus.done            = done_q;
endmodule
